// File: rtl/button_conditioner_pkg.sv
// Shared constants and the combo-reset FSM state type for button_conditioner.
// The combo FSM is only built when BUTTON_CONDITIONER_COMBO_RESET_EN is defined.
package button_conditioner_pkg;

    localparam int NUM_INPUTS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        FIRE     = 2'd2,
        WAIT_REL = 2'd3
    } combo_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One push-button channel: 2-flop synchronizer, stability counter, clean level
// and registered press/release pulses that line up with the clean level change.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic RawIn,
    output logic Clean,
    output logic Pressed,
    output logic Released
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clean_q;
    logic          clean_d;
    logic          pressed_q;
    logic          pressed_d;
    logic          released_q;
    logic          released_d;

    // The counter only runs while the synchronized level disagrees with Clean,
    // so it tops out at CNT_LAST and can never wrap.
    always_comb begin
        cnt_d      = cnt_q;
        clean_d    = clean_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (sync2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            clean_d    = ~clean_q;
            pressed_d  = ~clean_q;
            released_d = clean_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            clean_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync1_q    <= RawIn;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            clean_q    <= clean_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign Clean    = clean_q;
    assign Pressed  = pressed_q;
    assign Released = released_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces four push-buttons and, with BUTTON_CONDITIONER_COMBO_RESET_EN defined,
// turns a held COMBO_MASK combination into a single registered ResetReq pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         HOLD_CYCLES     = 100000000,
    parameter int         PULSE_CYCLES    = 16,
    parameter logic [3:0] COMBO_MASK      = 4'b1001
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NUM_INPUTS-1:0] RawIn,
    output logic [NUM_INPUTS-1:0] Clean,
    output logic [NUM_INPUTS-1:0] Pressed,
    output logic [NUM_INPUTS-1:0] Released,
    output logic                  ResetReq
);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .Clk     (Clk),
            .Reset   (Reset),
            .RawIn   (RawIn[i]),
            .Clean   (Clean[i]),
            .Pressed (Pressed[i]),
            .Released(Released[i])
        );
    end

`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    combo_state_e  state_q;
    combo_state_e  state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [PW-1:0] pulse_q;
    logic [PW-1:0] pulse_d;
    logic          req_q;
    logic          req_d;
    logic          combo;

    assign combo = (Clean & COMBO_MASK) == COMBO_MASK;

    // The IDLE cycle that sees the combo counts as the first held cycle, so
    // ResetReq rises exactly HOLD_CYCLES cycles after the combo appears on Clean.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pulse_d = pulse_q;
        req_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (combo) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d = FIRE;
                        pulse_d = '0;
                        req_d   = 1'b1;
                    end else begin
                        state_d = ARM;
                        hold_d  = HW'(1);
                    end
                end
            end
            ARM: begin
                if (!combo) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = FIRE;
                    hold_d  = '0;
                    pulse_d = '0;
                    req_d   = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            FIRE: begin
                // Combo state is deliberately ignored here: the pulse always runs full width.
                if (pulse_q == PULSE_LAST) begin
                    state_d = WAIT_REL;
                    pulse_d = '0;
                end else begin
                    pulse_d = pulse_q + PW'(1);
                    req_d   = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!combo) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            pulse_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            req_q   <= req_d;
        end
    end

    assign ResetReq = req_q;

`else

    logic unused_cfg;
    assign unused_cfg = ^{COMBO_MASK, HOLD_CYCLES[0], PULSE_CYCLES[0]};
    assign ResetReq   = 1'b0;

`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, HOLD=8, PULSE=3, MASK=4'b1001.
// Combo expectations follow BUTTON_CONDITIONER_COMBO_RESET_EN (ResetReq stays 0 without it).
module tb_button_conditioner;
    import button_conditioner_pkg::*;

`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN
    localparam bit COMBO_EN = 1'b1;
`else
    localparam bit COMBO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] raw_in;
    logic [3:0] clean;
    logic [3:0] pressed;
    logic [3:0] released;
    logic       reset_req;

    int vectors;
    int miscompares;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .PULSE_CYCLES   (3),
        .COMBO_MASK     (4'b1001)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .RawIn   (raw_in),
        .Clean   (clean),
        .Pressed (pressed),
        .Released(released),
        .ResetReq(reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        raw_in = 4'b1111;
        tick(3);
        vectors++;
        if ({clean, pressed, released, reset_req} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got clean=%b pressed=%b released=%b req=%b, expected all 0",
                     clean, pressed, released, reset_req);
        end
        raw_in = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(8);
        vectors++;
        if ({clean, pressed, released, reset_req} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_settle: got clean=%b pressed=%b released=%b req=%b, expected all 0",
                     clean, pressed, released, reset_req);
        end
`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
`endif
    endtask

    task automatic test_single_press();
        logic [3:0] exp_clean;
        logic [3:0] exp_edge;
        raw_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_clean = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_edge  = (k == 6) ? 4'b0001 : 4'b0000;
            vectors++;
            if (clean !== exp_clean || pressed !== exp_edge || released !== 4'b0000) begin
                miscompares++;
                $display("FAIL press_b0 k=%0d: got clean=%b pressed=%b released=%b, expected clean=%b pressed=%b released=0000",
                         k, clean, pressed, released, exp_clean, exp_edge);
            end
        end
        raw_in = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_clean = (k >= 6) ? 4'b0000 : 4'b0001;
            exp_edge  = (k == 6) ? 4'b0001 : 4'b0000;
            vectors++;
            if (clean !== exp_clean || released !== exp_edge || pressed !== 4'b0000) begin
                miscompares++;
                $display("FAIL release_b0 k=%0d: got clean=%b pressed=%b released=%b, expected clean=%b pressed=0000 released=%b",
                         k, clean, pressed, released, exp_clean, exp_edge);
            end
        end
    endtask

    task automatic test_glitch();
        int widths[2];
        widths[0] = 1;
        widths[1] = 3;
        for (int w = 0; w < 2; w++) begin
            raw_in = 4'b0100;
            tick(widths[w]);
            raw_in = 4'b0000;
            for (int k = 1; k <= 10; k++) begin
                tick(1);
                vectors++;
                if ({clean, pressed, released} !== 12'd0) begin
                    miscompares++;
                    $display("FAIL glitch_w%0d k=%0d: got clean=%b pressed=%b released=%b, expected all 0000",
                             widths[w], k, clean, pressed, released);
                end
            end
        end
    endtask

    task automatic test_glitch_boundary();
        logic [3:0] exp_clean;
        logic [3:0] exp_p;
        logic [3:0] exp_r;
        raw_in = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 4) raw_in = 4'b0000;
            exp_clean = (k >= 6 && k <= 9) ? 4'b0100 : 4'b0000;
            exp_p     = (k == 6) ? 4'b0100 : 4'b0000;
            exp_r     = (k == 10) ? 4'b0100 : 4'b0000;
            vectors++;
            if (clean !== exp_clean || pressed !== exp_p || released !== exp_r) begin
                miscompares++;
                $display("FAIL pulse4_b2 k=%0d: got clean=%b pressed=%b released=%b, expected clean=%b pressed=%b released=%b",
                         k, clean, pressed, released, exp_clean, exp_p, exp_r);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_clean;
        logic [3:0] exp_edge;
        raw_in = 4'b1010;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_clean = (k >= 6) ? 4'b1010 : 4'b0000;
            exp_edge  = (k == 6) ? 4'b1010 : 4'b0000;
            vectors++;
            if (clean !== exp_clean || pressed !== exp_edge) begin
                miscompares++;
                $display("FAIL simul_press k=%0d: got clean=%b pressed=%b, expected clean=%b pressed=%b",
                         k, clean, pressed, exp_clean, exp_edge);
            end
        end
        raw_in = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_edge = (k == 6) ? 4'b1010 : 4'b0000;
            vectors++;
            if (released !== exp_edge) begin
                miscompares++;
                $display("FAIL simul_release k=%0d: got released=%b expected %b", k, released, exp_edge);
            end
        end
    endtask

    task automatic test_combo_hold();
        logic exp_req;
        raw_in = 4'b1001;
        tick(6);
        vectors++;
        if (clean !== 4'b1001 || pressed !== 4'b1001) begin
            miscompares++;
            $display("FAIL combo_clean: got clean=%b pressed=%b expected 1001/1001", clean, pressed);
        end
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            exp_req = COMBO_EN && (k >= 8) && (k <= 10);
            vectors++;
            if (reset_req !== exp_req) begin
                miscompares++;
                $display("FAIL combo_req k=%0d: got %b expected %b", k, reset_req, exp_req);
            end
        end
`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN
        vectors++;
        if (dut.state_q !== WAIT_REL) begin
            miscompares++;
            $display("FAIL combo_wait_state: got %0d expected %0d", dut.state_q, WAIT_REL);
        end
`endif
        raw_in = 4'b0000;
        tick(6);
        vectors++;
        if (released !== 4'b1001 || clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL combo_release: got clean=%b released=%b expected 0000/1001", clean, released);
        end
        tick(2);
`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL combo_idle_state: got %0d expected %0d", dut.state_q, IDLE);
        end
`endif
    endtask

    task automatic test_combo_break();
        logic exp_req;
        raw_in = 4'b1001;
        tick(6);
        raw_in = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            vectors++;
            if (reset_req !== 1'b0) begin
                miscompares++;
                $display("FAIL break_req k=%0d: got %b expected 0", k, reset_req);
            end
        end
        vectors++;
        if (clean !== 4'b0001) begin
            miscompares++;
            $display("FAIL break_clean: got %b expected 0001", clean);
        end
        raw_in = 4'b1001;
        tick(6);
        vectors++;
        if (clean !== 4'b1001 || pressed !== 4'b1000) begin
            miscompares++;
            $display("FAIL repress_clean: got clean=%b pressed=%b expected 1001/1000", clean, pressed);
        end
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            exp_req = COMBO_EN && (k >= 8) && (k <= 10);
            vectors++;
            if (reset_req !== exp_req) begin
                miscompares++;
                $display("FAIL repress_req k=%0d: got %b expected %b", k, reset_req, exp_req);
            end
        end
        raw_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_reset_during_fire();
        logic       exp_req;
        logic [3:0] exp_p;
        raw_in = 4'b1001;
        tick(6);
        tick(8);
        vectors++;
        if (reset_req !== COMBO_EN) begin
            miscompares++;
            $display("FAIL fire_start: got %b expected %b", reset_req, COMBO_EN);
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++;
        if (reset_req !== 1'b0 || clean !== 4'b0000 || pressed !== 4'b0000) begin
            miscompares++;
            $display("FAIL fire_abort: got req=%b clean=%b pressed=%b expected 0/0000/0000",
                     reset_req, clean, pressed);
        end
`ifdef BUTTON_CONDITIONER_COMBO_RESET_EN
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL fire_abort_state: got %0d expected %0d", dut.state_q, IDLE);
        end
`endif
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            exp_p = (k == 6) ? 4'b1001 : 4'b0000;
            vectors++;
            if (pressed !== exp_p || reset_req !== 1'b0) begin
                miscompares++;
                $display("FAIL rehold_press k=%0d: got pressed=%b req=%b expected %b/0", k, pressed, reset_req, exp_p);
            end
        end
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            exp_req = COMBO_EN && (k >= 8) && (k <= 10);
            vectors++;
            if (reset_req !== exp_req) begin
                miscompares++;
                $display("FAIL rehold_req k=%0d: got %b expected %b", k, reset_req, exp_req);
            end
        end
        raw_in = 4'b0000;
        tick(10);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        raw_in      = 4'b0000;
        test_reset();
        test_single_press();
        test_glitch();
        test_glitch_boundary();
        test_simultaneous();
        test_combo_hold();
        test_combo_break();
        test_reset_during_fire();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
